// File: rtl/fsm_4s_step_ctrl.sv
// Sequential shell around the 4-state Moore comb stage. It holds the state register,
// runs the input/output val/rdy handshakes and keeps the step and detection counters.
module fsm_4s_step_ctrl #(
  parameter int NBITS_CNT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_val,
  output logic                 in_rdy,
  input  logic [1:0]           in_msg,
  output logic [1:0]           state,
  output logic [1:0]           comb_in,
  input  logic [1:0]           state_next,
  input  logic                 out,
  output logic                 out_val,
  input  logic                 out_rdy,
  output logic                 out_msg,
  output logic [NBITS_CNT-1:0] step_count,
  output logic [NBITS_CNT-1:0] det_count
);

  typedef enum logic [1:0] {
    ST_A = 2'd0,
    ST_B = 2'd1,
    ST_C = 2'd2,
    ST_D = 2'd3
  } state_t;

  localparam logic [NBITS_CNT-1:0] CNT_MAX = '1;

  state_t               state_q, state_d;
  logic                 out_val_d;
  logic [NBITS_CNT-1:0] step_d, det_d;
  logic                 in_fire, out_fire;

  // The comb stage sees the raw symbol; out_msg is its Moore output, so it only
  // follows the registered state and never the incoming symbol.
  assign comb_in  = in_msg;
  assign out_msg  = out;
  assign state    = state_q;

  assign in_rdy   = !out_val || out_rdy;
  assign in_fire  = in_val && in_rdy;
  assign out_fire = out_val && out_rdy;

  // NOTE: every variable written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    out_val_d = out_val;
    step_d    = step_count;
    det_d     = det_count;

    // A simultaneous input fire keeps out_val high so the next token follows back-to-back.
    if (in_fire) begin
      state_d   = state_t'(state_next);
      out_val_d = 1'b1;
      step_d    = step_count + 1'b1;
    end else if (out_fire) begin
      out_val_d = 1'b0;
    end

    if (out_fire && out_msg && (det_count != CNT_MAX)) begin
      det_d = det_count + 1'b1;
    end

    if (clear) begin
      step_d = '0;
      det_d  = '0;
    end
  end

  // NOTE: non-blocking assignments make every register sample pre-edge values,
  // independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_A;
      out_val    <= 1'b0;
      step_count <= '0;
      det_count  <= '0;
    end else begin
      state_q    <= state_d;
      out_val    <= out_val_d;
      step_count <= step_d;
      det_count  <= det_d;
    end
  end

endmodule

// File: tb/tb_fsm_4s_step_ctrl.sv
// Bench for fsm_4s_step_ctrl: directed vector table, a saturation run on a 2-bit
// counter instance, and a random run against a queue-based scoreboard.
module tb_fsm_4s_step_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, NBITS_CNT = 8
  logic       reset, clear, in_val, in_rdy, out, out_val, out_rdy, out_msg;
  logic [1:0] in_msg, state, comb_in, state_next;
  logic [7:0] step_count, det_count;

  // Saturation instance, NBITS_CNT = 2
  logic       s_reset, s_clear, s_in_val, s_in_rdy, s_out, s_out_val, s_out_rdy, s_out_msg;
  logic [1:0] s_in_msg, s_state, s_comb_in, s_state_next;
  logic [1:0] s_step_count, s_det_count;

  fsm_4s_step_ctrl #(.NBITS_CNT(8)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
    .state(state), .comb_in(comb_in), .state_next(state_next), .out(out),
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
    .step_count(step_count), .det_count(det_count)
  );

  fsm_4s_step_ctrl #(.NBITS_CNT(2)) dut_sat (
    .clk(clk), .reset(s_reset), .clear(s_clear),
    .in_val(s_in_val), .in_rdy(s_in_rdy), .in_msg(s_in_msg),
    .state(s_state), .comb_in(s_comb_in), .state_next(s_state_next), .out(s_out),
    .out_val(s_out_val), .out_rdy(s_out_rdy), .out_msg(s_out_msg),
    .step_count(s_step_count), .det_count(s_det_count)
  );

  // Team comb stage: next state for in = 00/01/10/11, output high only in D.
  function automatic logic [1:0] comb_next(input logic [1:0] s, input logic [1:0] i);
    logic [7:0] row;
    case (s)
      2'd0:    row = {2'd3, 2'd0, 2'd1, 2'd0};
      2'd1:    row = {2'd3, 2'd0, 2'd1, 2'd2};
      2'd2:    row = {2'd3, 2'd0, 2'd3, 2'd0};
      default: row = {2'd3, 2'd0, 2'd1, 2'd2};
    endcase
    return row[i*2 +: 2];
  endfunction

  always_comb begin
    state_next   = comb_next(state, comb_in);
    out          = (state == 2'd3);
    s_state_next = comb_next(s_state, s_comb_in);
    s_out        = (s_state == 2'd3);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst, clr, val;
    logic [1:0] msg;
    logic       rdy;
    logic       exp_in_rdy;
    logic [1:0] exp_state;
    logic       exp_ov, exp_om;
    logic [7:0] exp_step, exp_det;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, clr, val, input logic [1:0] msg, input logic rdy,
                              input logic ein, input logic [1:0] est, input logic eov, eom,
                              input logic [7:0] estep, edet);
    vec_t v;
    v.rst = rst; v.clr = clr; v.val = val; v.msg = msg; v.rdy = rdy;
    v.exp_in_rdy = ein; v.exp_state = est; v.exp_ov = eov; v.exp_om = eom;
    v.exp_step = estep; v.exp_det = edet;
    return v;
  endfunction

  // Drive one vector, check in_rdy mid-cycle, then the registered outputs after the edge.
  task automatic apply_vec(input vec_t v, input int idx);
    reset = v.rst; clear = v.clr; in_val = v.val; in_msg = v.msg; out_rdy = v.rdy;
    #1;
    check($sformatf("vec%0d in_rdy", idx), 32'(in_rdy), 32'(v.exp_in_rdy));
    @(posedge clk);
    #1;
    check($sformatf("vec%0d state", idx),   32'(state),      32'(v.exp_state));
    check($sformatf("vec%0d out_val", idx), 32'(out_val),    32'(v.exp_ov));
    check($sformatf("vec%0d out_msg", idx), 32'(out_msg),    32'(v.exp_om));
    check($sformatf("vec%0d step", idx),    32'(step_count), 32'(v.exp_step));
    check($sformatf("vec%0d det", idx),     32'(det_count),  32'(v.exp_det));
    @(negedge clk);
  endtask

  // Scoreboard: pending tokens in a queue, state tracked through the comb table.
  logic [1:0] m_state;
  bit         m_q[$];
  int         m_step, m_det;

  task automatic rand_step(input logic rst, clr, val, input logic [1:0] msg, input logic rdy);
    bit exp_rdy, ifire, ofire, tok;
    reset = rst; clear = clr; in_val = val; in_msg = msg; out_rdy = rdy;
    #1;
    exp_rdy = (m_q.size() == 0) || rdy;
    check("rnd in_rdy",  32'(in_rdy),  32'(exp_rdy));
    check("rnd out_val", 32'(out_val), 32'(m_q.size() != 0));
    check("rnd comb_in", 32'(comb_in), 32'(msg));
    if (m_q.size() != 0) check("rnd out_msg", 32'(out_msg), 32'(m_q[0]));
    ifire = val && exp_rdy;
    ofire = (m_q.size() != 0) && rdy;
    if (rst) begin
      m_q.delete();
      m_state = 2'd0;
      m_step  = 0;
      m_det   = 0;
    end else begin
      if (ofire) begin
        tok = m_q.pop_front();
        if (tok && m_det < 255) m_det++;
      end
      if (ifire) begin
        m_state = comb_next(m_state, msg);
        m_q.push_back(m_state == 2'd3);
        m_step = (m_step + 1) % 256;
      end
      if (clr) begin
        m_step = 0;
        m_det  = 0;
      end
    end
    @(posedge clk);
    #1;
    check("rnd state", 32'(state),      32'(m_state));
    check("rnd step",  32'(step_count), 32'(m_step));
    check("rnd det",   32'(det_count),  32'(m_det));
    @(negedge clk);
  endtask

  initial begin
    int exp_det;
    reset = 1'b1; clear = 1'b0; in_val = 1'b0; in_msg = 2'd0; out_rdy = 1'b1;
    s_reset = 1'b1; s_clear = 1'b0; s_in_val = 1'b0; s_in_msg = 2'd0; s_out_rdy = 1'b1;

    //                rst clr val msg   rdy  in_rdy state ov om step det
    // Reset then stream 01,00,01
    vecs.push_back(mk(1, 0, 0, 2'd0, 1,  1, 2'd0, 0, 0, 8'd0, 8'd0));
    vecs.push_back(mk(0, 0, 1, 2'd1, 1,  1, 2'd1, 1, 0, 8'd1, 8'd0));
    vecs.push_back(mk(0, 0, 1, 2'd0, 1,  1, 2'd2, 1, 0, 8'd2, 8'd0));
    vecs.push_back(mk(0, 0, 1, 2'd1, 1,  1, 2'd3, 1, 1, 8'd3, 8'd0));
    vecs.push_back(mk(0, 0, 0, 2'd0, 1,  1, 2'd3, 0, 1, 8'd3, 8'd1));
    // Backpressure: from A accept 11, hold out_rdy low while 00 is offered
    vecs.push_back(mk(1, 0, 0, 2'd0, 1,  1, 2'd0, 0, 0, 8'd0, 8'd0));
    vecs.push_back(mk(0, 0, 1, 2'd3, 0,  1, 2'd3, 1, 1, 8'd1, 8'd0));
    vecs.push_back(mk(0, 0, 1, 2'd0, 0,  0, 2'd3, 1, 1, 8'd1, 8'd0));
    vecs.push_back(mk(0, 0, 1, 2'd0, 0,  0, 2'd3, 1, 1, 8'd1, 8'd0));
    vecs.push_back(mk(0, 0, 1, 2'd0, 0,  0, 2'd3, 1, 1, 8'd1, 8'd0));
    vecs.push_back(mk(0, 0, 1, 2'd0, 1,  1, 2'd2, 1, 0, 8'd2, 8'd1));
    vecs.push_back(mk(0, 0, 0, 2'd0, 1,  1, 2'd2, 0, 0, 8'd2, 8'd1));
    // Clear collides with an output fire carrying 1
    vecs.push_back(mk(0, 0, 1, 2'd3, 1,  1, 2'd3, 1, 1, 8'd3, 8'd1));
    vecs.push_back(mk(0, 1, 0, 2'd0, 1,  1, 2'd3, 0, 1, 8'd0, 8'd0));
    // Reset with a token pending in D drops it
    vecs.push_back(mk(0, 0, 1, 2'd3, 0,  1, 2'd3, 1, 1, 8'd1, 8'd0));
    vecs.push_back(mk(1, 0, 1, 2'd0, 1,  1, 2'd0, 0, 0, 8'd0, 8'd0));
    vecs.push_back(mk(0, 0, 0, 2'd0, 1,  1, 2'd0, 0, 0, 8'd0, 8'd0));

    foreach (vecs[i]) apply_vec(vecs[i], i);

    // Saturation and wrap on the 2-bit instance: alternate 11,10 for 10 steps.
    s_reset = 1'b1;
    @(posedge clk);
    #1;
    check("sat reset step", 32'(s_step_count), 32'd0);
    check("sat reset det",  32'(s_det_count),  32'd0);
    @(negedge clk);
    s_reset = 1'b0;
    exp_det = 0;
    for (int i = 0; i < 10; i++) begin
      s_in_val = 1'b1;
      s_in_msg = (i % 2 == 0) ? 2'd3 : 2'd2;
      // Symbol i-1 is delivered in cycle i; even-indexed symbols lead to D.
      if (i >= 1 && ((i - 1) % 2 == 0) && exp_det < 3) exp_det++;
      @(posedge clk);
      #1;
      check($sformatf("sat%0d state", i), 32'(s_state),      32'((i % 2 == 0) ? 3 : 0));
      check($sformatf("sat%0d step", i),  32'(s_step_count), 32'((i + 1) % 4));
      check($sformatf("sat%0d det", i),   32'(s_det_count),  32'(exp_det));
      @(negedge clk);
    end
    s_in_val = 1'b0;
    @(posedge clk);
    #1;
    check("sat final out_val", 32'(s_out_val),    32'd0);
    check("sat final step",    32'(s_step_count), 32'd2);
    check("sat final det",     32'(s_det_count),  32'd3);
    @(negedge clk);

    // Random run against the scoreboard, starting from a fresh reset.
    reset = 1'b1; clear = 1'b0; in_val = 1'b0; out_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_q.delete();
    m_state = 2'd0;
    m_step  = 0;
    m_det   = 0;
    for (int i = 0; i < 10000; i++) begin
      rand_step($urandom_range(0, 1023) == 0, $urandom_range(0, 63) == 0,
                $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                $urandom_range(0, 2) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fsm_4s_step_ctrl.md
# fsm_4s_step_ctrl

Sequential shell for the team's 4-state, 2-input, 1-output Moore next-state/output stage. It owns the state register and accepts 2-bit input symbols over a val/rdy stream. It drives the comb stage with the current state and symbol, and latches `state_next` when a symbol is accepted. It emits one Moore output token per accepted symbol over a second val/rdy stream, and keeps step and detection counters for the rest of the datapath.

## Interface
- `NBITS_CNT`, default 8: width of `step_count` and `det_count`.

- `clk`  input  1  clock
- `reset`  input  1  synchronous, active-high reset
- `clear`  input  1  synchronous counter clear; does not affect state
- `in_val`  input  1  input symbol valid
- `in_rdy`  output  1  input symbol ready
- `in_msg`  input  2  input symbol
- `state`  output  2  current state register, drives the comb stage `state`
- `comb_in`  output  2  symbol to the comb stage `in_`; equals `in_msg`
- `state_next`  input  2  from the comb stage
- `out`  input  1  Moore output from the comb stage, a function of `state` only
- `out_val`  output  1  output token valid
- `out_rdy`  input  1  output token ready
- `out_msg`  output  1  output token value
- `step_count`  output  NBITS_CNT  count of accepted input symbols, wraps
- `det_count`  output  NBITS_CNT  count of accepted output tokens with value 1, saturates

## Operation
- State encoding is A=0, B=1, C=2, D=3. The block holds no transition table; all next-state and output decisions come from the comb stage.
- `comb_in = in_msg`, combinational.
- `in_rdy = !out_val || out_rdy`. An input fires when `in_val && in_rdy`.
- **Input fire:**
  - `state <= state_next`
  - `out_val <= 1`
  - `step_count <= step_count + 1`, modulo 2^NBITS_CNT
- **Output fire** (`out_val && out_rdy`) with no input fire in the same cycle: `out_val <= 0`.
- **Output fire and input fire in the same cycle:** `out_val` stays 1 and the new token follows back-to-back.
- `out_msg = out`, combinational. It is valid whenever `out_val` is high.
- While a token is pending (`out_val && !out_rdy`), `in_rdy` is 0. `state` therefore cannot change, and `out_msg` stays stable.
- **Detection count:** on output fire with `out_msg == 1`, `det_count` increments. It saturates at 2^NBITS_CNT-1 and does not wrap.
- **Clear:** `clear` zeroes both counters next cycle. It has priority over any increment in the same cycle. State, `out_val`, and handshakes proceed normally.
- **Reset:** `state`=A, `out_val`=0, `step_count`=0, `det_count`=0. Reset has priority over `clear` and over both fires. A token pending at reset is dropped.
- The block does not check `in_msg` or `state_next` values; all 2-bit codes are legal.

## Timing
- Input fire in cycle t gives:
  - updated `state` and `out_val`=1 in cycle t+1;
  - `out_msg` reflecting the new state in cycle t+1 (one comb delay after the register);
  - `step_count` updated in cycle t+1.
- Throughput is one symbol per cycle while `out_rdy` is held high.
- Output fire in cycle t gives `det_count` updated in cycle t+1.
- `in_rdy` depends combinationally on `out_rdy`. `out_rdy` must not depend combinationally on `in_rdy`.
- No combinational path from `in_msg` to `out_msg`.
- Reset values hold in the cycle after `reset` is sampled high. `in_rdy`=1 during and after reset.

## Test plan
The bench instantiates the existing comb stage. Its transitions, as next state for in=00/01/10/11:
- A: A/B/A/D
- B: C/B/A/D
- C: A/D/A/D
- D: C/B/A/D

Output `out`=1 only in state D.

- **Reset then stream.** Reset, then feed symbols 01,00,01 with `out_rdy`=1 every cycle.
  - States go B,C,D.
  - `out_msg` tokens are 0,0,1 on consecutive cycles.
  - `step_count`=3, `det_count`=1.
- **Backpressure.** From A, feed 11 and hold `out_rdy`=0 for 3 cycles.
  - `state`=D and `out_val`=1 throughout; `in_rdy`=0.
  - A second offered symbol 00 is not accepted until `out_rdy`=1.
  - Then the state goes to C and the token values are 1 then 0.
- **Saturation and wrap.** With NBITS_CNT=2, alternate symbols 11,10 for 10 steps.
  - `det_count` stops at 3.
  - `step_count` wraps to 2.
- **Clear collision.** Assert `clear` in the same cycle as an output fire with value 1.
  - `det_count`=0 next cycle.
  - `state` unaffected.
- **Reset mid-operation.** Enter D with a pending token, then assert `reset`.
  - Next cycle `state`=A, `out_val`=0, counters 0.
  - No token delivered.
- **Random.** 10k random symbols and random `out_rdy`, checked against a scoreboard model.
  - Tokens are in order and one per accepted symbol.
  - `det_count` matches the scoreboard.
